// File: rtl/nn_pkg.sv
// Shared Q8.8 types and constants for the XOR network scheduler slice.
package nn_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 8;

    typedef logic signed [DATA_W-1:0] q8_8_t;

    localparam q8_8_t ZERO = 16'sh0000;
    localparam q8_8_t HALF = q8_8_t'(1 << (FRAC_W - 1));
    localparam q8_8_t ONE  = q8_8_t'(1 << FRAC_W);

    // Response payload: requester id, raw network result, thresholded decision
    typedef struct packed {
        logic  id;
        q8_8_t raw;
        logic  dbit;
    } nn_rsp_t;

endpackage

// File: rtl/nn_rsp_fifo.sv
// Synchronous response FIFO with registered full/empty; head is always visible on rd_data.
module nn_rsp_fifo
    import nn_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  nn_rsp_t wr_data,
    input  logic    rd_en,
    output nn_rsp_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    nn_rsp_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_nxt = count;
        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // The credit limit upstream makes a write into a full FIFO unreachable
    assert property (@(posedge clk) disable iff (!rst) !(wr_en && full));

endmodule

// File: rtl/nn_xor_scheduler.sv
// Round-robin scheduler feeding the shared XOR network, tracking in-flight ops
// through its fixed latency and returning tagged results via a buffered port.
module nn_xor_scheduler
    import nn_pkg::*;
#(
    parameter int unsigned              DATA_W    = 16,
    parameter int unsigned              LATENCY   = 2,
    parameter int unsigned              OUT_DEPTH = 4,
    parameter logic signed [DATA_W-1:0] THRESH    = HALF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic signed [DATA_W-1:0] req0_a,
    input  logic signed [DATA_W-1:0] req0_b,
    input  logic signed [DATA_W-1:0] req0_c,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic signed [DATA_W-1:0] req1_a,
    input  logic signed [DATA_W-1:0] req1_b,
    input  logic signed [DATA_W-1:0] req1_c,
    output logic signed [DATA_W-1:0] net_a,
    output logic signed [DATA_W-1:0] net_b,
    output logic signed [DATA_W-1:0] net_c,
    input  logic signed [DATA_W-1:0] net_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic signed [DATA_W-1:0] rsp_raw,
    output logic                     rsp_bit
);

    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    logic [CNT_W-1:0] outstanding;
    logic             last_grant;
    logic [LATENCY:0] tag_v;
    logic [LATENCY:0] tag_id;

    logic    credit_ok;
    logic    winner;
    logic    acc0;
    logic    acc1;
    logic    accept;
    logic    rsp_pop;
    logic    fifo_full;
    logic    fifo_empty;
    nn_rsp_t fifo_in;
    nn_rsp_t fifo_head;

    // Credit uses the pre-edge count; readies stay low while in reset
    assign credit_ok = rst && (outstanding < CNT_W'(OUT_DEPTH));

    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = !last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign req0_ready = credit_ok && !winner;
    assign req1_ready = credit_ok && winner;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign accept     = acc0 || acc1;
    assign rsp_pop    = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            net_a       <= ZERO;
            net_b       <= ZERO;
            net_c       <= ZERO;
            tag_v       <= '0;
            tag_id      <= '0;
            last_grant  <= 1'b1;
            outstanding <= '0;
        end else begin
            if (acc1) begin
                net_a <= req1_a;
                net_b <= req1_b;
                net_c <= req1_c;
            end else if (acc0) begin
                net_a <= req0_a;
                net_b <= req0_b;
                net_c <= req0_c;
            end else begin
                net_a <= ZERO;
                net_b <= ZERO;
                net_c <= ZERO;
            end
            tag_v  <= {tag_v[LATENCY-1:0], accept};
            tag_id <= {tag_id[LATENCY-1:0], acc1};
            if (accept) begin
                last_grant <= acc1;
            end
            unique case ({accept, rsp_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // A tag leaving the last stage means net_result now belongs to that op
    assign fifo_in = '{id: tag_id[LATENCY], raw: net_result, dbit: (net_result > THRESH)};

    nn_rsp_fifo #(
        .DEPTH(OUT_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (tag_v[LATENCY]),
        .wr_data(fifo_in),
        .rd_en  (rsp_ready),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_head.id;
    assign rsp_raw   = fifo_head.raw;
    assign rsp_bit   = fifo_head.dbit;

endmodule

// File: tb/tb_nn_xor_scheduler.sv
// Bench for nn_xor_scheduler: behavioural network delay line, scoreboard of
// expected responses, vector table plus arbitration/back-pressure/reset sequences.
module tb_nn_xor_scheduler;

    localparam logic signed [15:0] Q_ZERO = 16'sh0000;
    localparam logic signed [15:0] Q_ONE  = 16'sh0100;
    localparam int                 DEPTH  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic signed [15:0] req0_a, req0_b, req0_c;
    logic signed [15:0] req1_a, req1_b, req1_c;
    logic signed [15:0] net_a, net_b, net_c, net_result;
    logic               rsp_valid, rsp_ready, rsp_id, rsp_bit;
    logic signed [15:0] rsp_raw;

    nn_xor_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_c    (req0_c),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_c    (req1_c),
        .net_a     (net_a),
        .net_b     (net_b),
        .net_c     (net_c),
        .net_result(net_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_raw   (rsp_raw),
        .rsp_bit   (rsp_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Network model: mode 0 = ideal XOR network, mode 1 = stub passing net_a through
    int                 mode = 0;
    logic signed [15:0] d0, d1;

    function automatic logic xor3(input logic signed [15:0] a, b, c);
        return (a == Q_ONE) ^ (b == Q_ONE) ^ (c == Q_ONE);
    endfunction

    always @(posedge clk) begin
        if (mode == 0) d0 <= xor3(net_a, net_b, net_c) ? Q_ONE : Q_ZERO;
        else           d0 <= net_a;
        d1 <= d0;
    end
    assign net_result = d1;

    typedef struct {
        logic               id;
        logic signed [15:0] raw;
        logic               rbit;
    } exp_t;

    typedef struct {
        int                 mode;
        logic signed [15:0] a, b, c;
        logic signed [15:0] exp_raw;
        logic               exp_bit;
    } vec_t;

    exp_t sb[$];
    int   grant_log[$];
    int   acc_edge[$];
    int   pop_edge[$];
    int   model_out = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic record(input int id, input logic signed [15:0] a, b, c);
        exp_t e;
        e.id = id[0];
        if (mode == 0) begin
            e.rbit = xor3(a, b, c);
            e.raw  = e.rbit ? Q_ONE : Q_ZERO;
        end else begin
            e.raw  = a;
            e.rbit = (a > 16'sh0080);
        end
        sb.push_back(e);
        grant_log.push_back(id);
        acc_edge.push_back(cyc + 1);
        model_out++;
    endtask

    // Monitor: sample mid-cycle what the coming edge will do
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_in_reset", 32'({req0_ready, req1_ready}), 32'd0);
            model_out = 0;
            sb.delete();
        end else begin
            check("credit", 32'(req0_ready | req1_ready), 32'(model_out < DEPTH));
            if (req0_valid && req0_ready) record(0, req0_a, req0_b, req0_c);
            if (req1_valid && req1_ready) record(1, req1_a, req1_b, req1_c);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL stale_rsp: got id=%0d raw=%0h with nothing expected", rsp_id, rsp_raw);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_id",  32'(rsp_id),  32'(e.id));
                    check("sb_raw", 32'(rsp_raw), 32'(e.raw));
                    check("sb_bit", 32'(rsp_bit), 32'(e.rbit));
                end
                pop_edge.push_back(cyc + 1);
                model_out--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input string name);
        int k = 0;
        while (grant_log.size() < target && k < 20) begin
            tick();
            k++;
        end
        check(name, 32'(grant_log.size() >= target), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || rsp_valid) && k < 40) begin
            tick();
            k++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    vec_t vt[11];

    initial begin
        int s, sp, lat, cnt;

        for (int i = 0; i < 8; i++) begin
            vt[i].mode    = 0;
            vt[i].a       = i[2] ? Q_ONE : Q_ZERO;
            vt[i].b       = i[1] ? Q_ONE : Q_ZERO;
            vt[i].c       = i[0] ? Q_ONE : Q_ZERO;
            vt[i].exp_bit = i[2] ^ i[1] ^ i[0];
            vt[i].exp_raw = vt[i].exp_bit ? Q_ONE : Q_ZERO;
        end
        vt[8]  = '{1, 16'sh0080, Q_ZERO, Q_ZERO, 16'sh0080, 1'b0};
        vt[9]  = '{1, 16'sh0081, Q_ZERO, Q_ZERO, 16'sh0081, 1'b1};
        vt[10] = '{1, 16'shFF00, Q_ZERO, Q_ZERO, 16'shFF00, 1'b0};

        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_c = '0;
        req1_a = '0; req1_b = '0; req1_c = '0;
        repeat (3) tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_raw",   32'(rsp_raw),   32'd0);
        check("rst_rsp_bit",   32'(rsp_bit),   32'd0);
        check("rst_net_a",     32'(net_a),     32'd0);
        rst = 1'b1;
        tick();

        // Both requesters valid, consumer always ready: alternation from req0
        rsp_ready = 1'b1;
        req0_a = Q_ONE; req0_b = Q_ZERO; req0_c = Q_ZERO;
        req1_a = Q_ONE; req1_b = Q_ONE;  req1_c = Q_ZERO;
        s = grant_log.size();
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (20) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count_min", 32'(grant_log.size() - s >= 8), 32'd1);
        for (int i = 0; i < 8; i++) check($sformatf("rr_grant%0d", i), 32'(grant_log[s+i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check($sformatf("rr_b2b%0d", i), 32'(acc_edge[s+i] - acc_edge[s]), 32'(i));
        wait_drain("rr_drain");

        // Back-pressure: exactly DEPTH accepts, then resume one cycle after first pop
        rsp_ready = 1'b0;
        s = grant_log.size();
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (12) tick();
        check("bp_accepts", 32'(grant_log.size() - s), 32'(DEPTH));
        check("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
        sp = pop_edge.size();
        rsp_ready = 1'b1;
        wait_acc(s + DEPTH + 1, "bp_resume");
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("bp_popped", 32'(pop_edge.size() > sp), 32'd1);
        if (pop_edge.size() > sp && grant_log.size() > s + DEPTH)
            check("bp_resume_gap", 32'(acc_edge[s+DEPTH] - pop_edge[sp]), 32'd1);
        wait_drain("bp_drain");

        // Vector table: single ops from req0 through XOR network and stub
        foreach (vt[i]) begin
            mode = vt[i].mode;
            req0_a = vt[i].a; req0_b = vt[i].b; req0_c = vt[i].c;
            s = grant_log.size();
            req0_valid = 1'b1;
            wait_acc(s + 1, $sformatf("vec%0d_acc", i));
            req0_valid = 1'b0;
            check($sformatf("vec%0d_net", i), 32'({net_a, net_b}), 32'({vt[i].a, vt[i].b}));
            lat = 0;
            while (!rsp_valid && lat < 10) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_bit", i), 32'(rsp_bit), 32'(vt[i].exp_bit));
            check($sformatf("vec%0d_raw", i), 32'(rsp_raw), 32'(vt[i].exp_raw));
            check($sformatf("vec%0d_id", i),  32'(rsp_id),  32'd0);
            wait_drain($sformatf("vec%0d_drain", i));
        end
        mode = 0;

        // Reset with 3 ops in flight; last grant before reset is req0
        rsp_ready = 1'b0;
        req0_a = Q_ONE; req0_b = Q_ZERO; req0_c = Q_ZERO;
        s = grant_log.size();
        req0_valid = 1'b1;
        wait_acc(s + 3, "rst_fill");
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rr_net",       32'({net_a, net_b, net_c}), 32'd0);
        check("rr_rsp_raw",   32'(rsp_raw),   32'd0);
        rst = 1'b1;
        rsp_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            tick();
            if (rsp_valid) cnt++;
        end
        check("rr_no_stale", 32'(cnt), 32'd0);
        s = grant_log.size();
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_acc(s + 1, "rr_tie_acc");
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (grant_log.size() > s) check("rr_tie_grant", 32'(grant_log[s]), 32'd0);
        wait_drain("rr_final_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
